// File: rtl/demux_1to2_4bit_buf.sv
// 1-to-2 nibble demultiplexer: each input word is steered by S into one of two
// small per-output FIFOs so that each consumer can stall independently.

module demux_1to2_4bit_buf_fifo #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [3:0]       wdata,
    input  logic             out_ready,
    output logic             full,
    output logic             valid,
    output logic [3:0]       data,
    output logic [CNT_W-1:0] delivered
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [3:0]       mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_nxt_s;
    logic [PTR_W-1:0] rd_ptr_nxt_s;
    logic [PTR_W:0]   count_r;
    logic [PTR_W:0]   count_nxt_s;
    logic             full_r;
    logic             valid_r;
    logic [3:0]       head_r;
    logic [3:0]       head_nxt_s;
    logic [CNT_W-1:0] deliv_r;
    logic [CNT_W-1:0] deliv_nxt_s;
    logic             push_s;
    logic             pop_s;

    // A full FIFO never accepts, even if the parent forgets to gate the push.
    assign push_s = push && !full_r;
    assign pop_s  = valid_r && out_ready;

    // Next-state for pointers, occupancy and the delivered-word counter.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        deliv_nxt_s  = deliv_r;
        if (push_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
            deliv_nxt_s  = deliv_r + CNT_W'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
            deliv_nxt_s  = deliv_r;
        end
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + (PTR_W + 1)'(1);
            2'b01:   count_nxt_s = count_r - (PTR_W + 1)'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Head word for the next cycle; the slot being written only becomes the
    // head when the FIFO is otherwise empty after this cycle's pop.
    always_comb begin
        head_nxt_s = 4'h0;
        if (count_nxt_s == '0) begin
            head_nxt_s = 4'h0;
        end else if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_nxt_s = wdata;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Control state and registered output view of the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            valid_r  <= 1'b0;
            head_r   <= 4'h0;
            deliv_r  <= '0;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            full_r   <= (count_nxt_s == FULL_CNT);
            valid_r  <= (count_nxt_s != '0);
            head_r   <= head_nxt_s;
            deliv_r  <= deliv_nxt_s;
        end
    end

    // Storage array; contents are hidden behind valid so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    assign full      = full_r;
    assign valid     = valid_r;
    assign data      = head_r;
    assign delivered = deliv_r;

endmodule

module demux_1to2_4bit_buf #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [3:0]       Hyrja,
    input  logic             HyrjaValid,
    input  logic             S,
    output logic             HyrjaReady,
    output logic [3:0]       Dalja0,
    output logic             Dalja0Valid,
    input  logic             Dalja0Ready,
    output logic [3:0]       Dalja1,
    output logic             Dalja1Valid,
    input  logic             Dalja1Ready,
    output logic [CNT_W-1:0] Numri0,
    output logic [CNT_W-1:0] Numri1
);

    logic full0_s;
    logic full1_s;
    logic ready_s;
    logic push0_s;
    logic push1_s;

    // Ready looks only at the destination's registered full flag.
    assign ready_s    = S ? !full1_s : !full0_s;
    assign HyrjaReady = ready_s;
    assign push0_s    = HyrjaValid && ready_s && !S;
    assign push1_s    = HyrjaValid && ready_s && S;

    demux_1to2_4bit_buf_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo0 (
        .clk       (Clock),
        .rst_n     (Reset),
        .push      (push0_s),
        .wdata     (Hyrja),
        .out_ready (Dalja0Ready),
        .full      (full0_s),
        .valid     (Dalja0Valid),
        .data      (Dalja0),
        .delivered (Numri0)
    );

    demux_1to2_4bit_buf_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo1 (
        .clk       (Clock),
        .rst_n     (Reset),
        .push      (push1_s),
        .wdata     (Hyrja),
        .out_ready (Dalja1Ready),
        .full      (full1_s),
        .valid     (Dalja1Valid),
        .data      (Dalja1),
        .delivered (Numri1)
    );

endmodule
